// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Sequencing controller for the 16-point radix-2 FFT datapath.
// It collects serial real samples into 16-word frames and launches each frame.
// It captures the datapath result LAT cycles after the launch.
// It reorders the result from bit-reversed order to natural bin order.
// It then holds the result for a valid/ready consumer.
//
// Ports:
//   clk, rst_n   clock (rising edge), async active-low reset
//   fir_valid    fir_d carries a sample this cycle
//   fir_d        16-bit signed real sample
//   fft_frame    launched frame, word k = {sample k, 16'h0000}
//   fft_launch   one-cycle pulse, fft_frame is new this cycle
//   fft_result   datapath output, bit-reversed word order
//   fft_out      reordered result, bin k at [32k+31:32k]
//   fft_valid    fft_out holds an unconsumed result
//   fft_ready    downstream accepts fft_out this cycle
//   overrun      sticky, a captured result was dropped
//   busy         a launched frame is in flight
module fft_frame_ctrl #(
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fir_valid,
    input  logic [15:0]  fir_d,
    output logic [511:0] fft_frame,
    output logic         fft_launch,
    input  logic [511:0] fft_result,
    output logic [511:0] fft_out,
    output logic         fft_valid,
    input  logic         fft_ready,
    output logic         overrun,
    output logic         busy
);
    localparam logic [3:0] LAT_C = 4'(LAT);

    typedef enum logic {T_IDLE, T_WAIT}  trk_t;
    typedef enum logic {O_EMPTY, O_FULL} out_t;

    logic [15:0]  fill_buf [16];
    logic [3:0]   wr_cnt;
    logic [3:0]   dly_cnt;
    logic [511:0] frame_next;
    logic [511:0] reordered;
    trk_t         trk_state, trk_next;
    out_t         out_state, out_next;
    logic         accept_last, capture, transfer, load_out, drop_out;

    assign accept_last = fir_valid && (wr_cnt == 4'd15);

    // ---------------- fill buffer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= 4'd0;
            for (int i = 0; i < 16; i++) fill_buf[i] <= 16'h0000;
        end else if (fir_valid) begin
            fill_buf[wr_cnt] <= fir_d;
            wr_cnt           <= wr_cnt + 4'd1;
        end
    end

    // Slot 15 is taken straight from fir_d so the launch does not wait
    // for the buffer write of the last sample.
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < 15; k++) frame_next[32*k +: 32] = {fill_buf[k], 16'h0000};
        frame_next[32*15 +: 32] = {fir_d, 16'h0000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fft_frame  <= '0;
            fft_launch <= 1'b0;
        end else begin
            fft_launch <= accept_last;
            if (accept_last) fft_frame <= frame_next;
        end
    end

    // ---------------- in-flight tracker ----------------
    // WAIT is entered on the accepting edge.  The launch cycle therefore
    // sees dly_cnt=0, and capture falls at the end of cycle launch+LAT.
    assign capture = (trk_state == T_WAIT) && (dly_cnt == LAT_C);
    assign busy    = (trk_state == T_WAIT) || fft_launch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_state <= T_IDLE;
            dly_cnt   <= 4'd0;
        end else begin
            trk_state <= trk_next;
            if (trk_state == T_IDLE) dly_cnt <= 4'd0;
            else                     dly_cnt <= dly_cnt + 4'd1;
        end
    end

    always_comb begin
        trk_next = trk_state;
        case (trk_state)
            T_IDLE:  if (accept_last) trk_next = T_WAIT;
            T_WAIT:  if (capture)     trk_next = T_IDLE;
            default: trk_next = T_IDLE;
        endcase
    end

    // ---------------- bit-reverse reorder ----------------
    for (genvar k = 0; k < 16; k++) begin : g_rev
        localparam int R = ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
        assign reordered[32*k +: 32] = fft_result[32*R +: 32];
    end

    // ---------------- output handshake ----------------
    assign fft_valid = (out_state == O_FULL);
    assign transfer  = fft_valid && fft_ready;
    // A held result is only replaced when it leaves on the same edge.
    assign load_out  = capture && ((out_state == O_EMPTY) || transfer);
    assign drop_out  = capture && (out_state == O_FULL) && !transfer;

    always_comb begin
        out_next = out_state;
        case (out_state)
            O_EMPTY: if (capture)              out_next = O_FULL;
            O_FULL:  if (transfer && !capture) out_next = O_EMPTY;
            default: out_next = O_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state <= O_EMPTY;
            fft_out   <= '0;
            overrun   <= 1'b0;
        end else begin
            out_state <= out_next;
            if (load_out) fft_out <= reordered;
            if (drop_out) overrun <= 1'b1;
        end
    end
endmodule
